// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer: buffers one packet, then emits length header + payload.
// Optional XOR trailer word when FIFO_PKT_WRITER_CHECKSUM_EN is defined.
module fifo_pkt_writer #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  input  logic             fifo_full,
  output logic             fifo_w_en,
  output logic [WIDTH-1:0] fifo_data,
  output logic             busy,
  output logic             err_overlen,
  output logic [15:0]      pkt_count
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
  typedef enum logic [2:0] {
    COLLECT, DROP, HDR, PAYLOAD, CSUM
  } state_t;
`else
  typedef enum logic [1:0] {
    COLLECT, DROP, HDR, PAYLOAD
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] mem [MAX_LEN];
  logic [LW-1:0]    len;
  logic [IW-1:0]    idx;
  logic             accept;
  logic             last_pl;
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
  logic [WIDTH-1:0] csum;
`endif

  assign s_ready = (state == COLLECT || state == DROP) && !w_rst;
  assign accept  = s_valid && s_ready;
  assign last_pl = (LW'(idx) == len - LW'(1));

`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
  assign busy = (state == HDR) || (state == PAYLOAD) || (state == CSUM);
`else
  assign busy = (state == HDR) || (state == PAYLOAD);
`endif

  assign fifo_w_en = busy && !fifo_full;

  // Output word mux; stable while the FIFO is full because state/idx hold.
  always_comb begin
    fifo_data = '0;
    unique case (1'b1)
      (state == HDR):     fifo_data = WIDTH'(len);
      (state == PAYLOAD): fifo_data = mem[idx];
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
      (state == CSUM):    fifo_data = csum;
`endif
      default:            fifo_data = '0;
    endcase
  end

  // Packet buffer: only written while collecting, so len is always in range.
  always_ff @(posedge w_clk) begin
    if (state == COLLECT && accept)
      mem[len[IW-1:0]] <= s_data;
  end

  // Framing FSM: collect, optionally drop overflow, then header and payload.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state       <= COLLECT;
      len         <= '0;
      idx         <= '0;
      err_overlen <= 1'b0;
      pkt_count   <= '0;
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            len <= len + LW'(1);
            if (s_last) begin
              state <= HDR;
            end else if (len == LW'(MAX_LEN - 1)) begin
              err_overlen <= 1'b1;
              state       <= DROP;
            end
          end
        end
        DROP: begin
          if (accept && s_last)
            state <= HDR;
        end
        HDR: begin
          if (fifo_w_en) begin
            idx   <= '0;
            state <= PAYLOAD;
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        PAYLOAD: begin
          if (fifo_w_en) begin
            idx <= idx + IW'(1);
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
            csum <= csum ^ mem[idx];
`endif
            if (last_pl) begin
              len <= '0;
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
              state <= CSUM;
`else
              state     <= COLLECT;
              pkt_count <= pkt_count + 16'd1;
`endif
            end
          end
        end
`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
        CSUM: begin
          if (fifo_w_en) begin
            state     <= COLLECT;
            pkt_count <= pkt_count + 16'd1;
          end
        end
`endif
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Scoreboard bench for fifo_pkt_writer: directed packets, expected FIFO
// words queued at issue time and popped by an independent write monitor.
module tb_fifo_pkt_writer;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_w_en;
  logic [7:0]  fifo_data;
  logic        busy;
  logic        err_overlen;
  logic [15:0] pkt_count;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_w;
  logic [7:0]  pk[$];
  int          stalls;

`ifdef FIFO_PKT_WRITER_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  fifo_pkt_writer #(.WIDTH(8), .MAX_LEN(16)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
    .fifo_data(fifo_data), .busy(busy),
    .err_overlen(err_overlen), .pkt_count(pkt_count)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: each negedge with w_en high is exactly one write at the next edge.
  initial begin
    forever begin
      @(negedge w_clk);
      if (!w_rst && fifo_w_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected actual=%0h required=none", fifo_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (fifo_data !== exp_w) begin
            errors++;
            $display("FAIL wr_data actual=%0h required=%0h", fifo_data, exp_w);
          end
        end
      end
    end
  end

  // Expected FIFO stream for a packet: header, first 16 words, optional XOR.
  task automatic expect_pkt(input logic [7:0] words[$]);
    int n;
    logic [7:0] x;
    n = (words.size() > 16) ? 16 : words.size();
    x = 8'h00;
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(words[i]);
      x = x ^ words[i];
    end
    if (EXTRA == 1) exp_q.push_back(x);
  endtask

  // Drive words from just after a posedge; count cycles spent not ready.
  task automatic send_pkt(input logic [7:0] words[$], output int nready);
    int t;
    nready = 0;
    for (int i = 0; i < words.size(); i++) begin
      s_valid = 1'b1;
      s_data  = words[i];
      s_last  = (i == words.size() - 1);
      t = 0;
      forever begin
        @(negedge w_clk);
        if (s_ready) break;
        nready++;
        t++;
        if (t > 200) begin
          chk("send_timeout", 32'(t), 32'd0);
          break;
        end
      end
      @(posedge w_clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 200) begin
      @(negedge w_clk);
      t++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    @(negedge w_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    @(negedge w_clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_w_en", fifo_w_en, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_overlen, 0);
    chk("rst_pkt", pkt_count, 0);
    @(posedge w_clk); #1;
    w_rst = 1'b0;
    @(negedge w_clk);
    chk("rel_s_ready", s_ready, 1);

    // 3-word packet: consecutive writes on edges k+1..k+4.
    pk.delete();
    pk.push_back(8'h11); pk.push_back(8'h22); pk.push_back(8'h33);
    @(posedge w_clk); #1;
    expect_pkt(pk);
    send_pkt(pk, stalls);
    for (int i = 0; i < 4 + EXTRA; i++) begin
      @(negedge w_clk);
      chk("t1_w_en", fifo_w_en, 1);
      chk("t1_s_ready", s_ready, 0);
    end
    @(negedge w_clk);
    chk("t1_busy", busy, 0);
    chk("t1_pkt", pkt_count, 1);
    drain("t1_drain");

    // Same packet with three full cycles after the header write.
    @(posedge w_clk); #1;
    expect_pkt(pk);
    send_pkt(pk, stalls);
    @(negedge w_clk);
    chk("t2_hdr_w_en", fifo_w_en, 1);
    chk("t2_hdr", fifo_data, 8'h03);
    @(posedge w_clk); #1;
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge w_clk);
      chk("t2_stall_w_en", fifo_w_en, 0);
      chk("t2_stall_data", fifo_data, 8'h11);
      chk("t2_stall_busy", busy, 1);
    end
    @(posedge w_clk); #1;
    fifo_full = 1'b0;
    drain("t2_drain");
    chk("t2_pkt", pkt_count, 2);

    // Single-word packet.
    pk.delete();
    pk.push_back(8'hA5);
    @(posedge w_clk); #1;
    expect_pkt(pk);
    send_pkt(pk, stalls);
    drain("t3_drain");
    chk("t3_pkt", pkt_count, 3);
    chk("t3_err", err_overlen, 0);

    // 20-word packet: truncated to 16, ready held through word 20.
    pk.delete();
    for (int i = 1; i <= 20; i++) pk.push_back(8'(i));
    @(posedge w_clk); #1;
    expect_pkt(pk);
    send_pkt(pk, stalls);
    chk("t4_nready", 32'(stalls), 0);
    chk("t4_err", err_overlen, 1);
    drain("t4_drain");
    chk("t4_pkt", pkt_count, 4);

    // Back-to-back packets with s_valid continuously high.
    pk.delete();
    pk.push_back(8'h40); pk.push_back(8'h41);
    @(posedge w_clk); #1;
    expect_pkt(pk);
    send_pkt(pk, stalls);
    pk.delete();
    pk.push_back(8'h50); pk.push_back(8'h51);
    expect_pkt(pk);
    send_pkt(pk, stalls);
    chk("t5_backpressure", 32'(stalls), 32'(3 + EXTRA));
    drain("t5_drain");
    chk("t5_pkt", pkt_count, 6);
    chk("t5_err_sticky", err_overlen, 1);

    // Reset in PAYLOAD at idx 1: packet abandoned.
    pk.delete();
    pk.push_back(8'h61); pk.push_back(8'h62); pk.push_back(8'h63);
    @(posedge w_clk); #1;
    expect_pkt(pk);
    send_pkt(pk, stalls);
    @(posedge w_clk);
    @(posedge w_clk); #1;
    chk("t6_pre_w_en", fifo_w_en, 1);
    chk("t6_pre_data", fifo_data, 8'h62);
    w_rst = 1'b1;
    #1;
    chk("t6_w_en_async", fifo_w_en, 0);
    chk("t6_busy_async", busy, 0);
    exp_q.delete();
    @(negedge w_clk);
    chk("t6_rst_s_ready", s_ready, 0);
    @(posedge w_clk); #1;
    w_rst = 1'b0;
    @(negedge w_clk);
    chk("t6_s_ready", s_ready, 1);
    chk("t6_pkt", pkt_count, 0);
    chk("t6_err", err_overlen, 0);
    chk("t6_data", fifo_data, 0);

    // Normal operation resumes after the abandoned packet.
    pk.delete();
    pk.push_back(8'h77); pk.push_back(8'h88);
    @(posedge w_clk); #1;
    expect_pkt(pk);
    send_pkt(pk, stalls);
    drain("t7_drain");
    chk("t7_pkt", pkt_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
